motion_detect_core: RTL and testbench
=====================================

// Module: motion_detect_core
// PURPOSE
//  Per-pixel motion-detection datapath plus frame-buffer address generator for the video motion detector.
//  Compares each incoming 32-bit RGB pixel against the stored background pixel of the same location.
//  Motion pixels are replaced with HIGHLIGHT_COLOR. Sits between the AXI-Stream/AXI-Lite wrapper FSM and memory.
// PARAMETERS
//  WIDTH_BITS       11            column counter / width config width
//  HEIGHT_BITS      10            row counter / height config width
//  STREAM_WIDTH     32            pixel width; RGB in [23:16]=R, [15:8]=G, [7:0]=B; [31:24] ignored
//  ADDR_WIDTH       32            memory address width
//  BASE_ADDR        32'h0         byte address of pixel 0 of the background buffer
//  HIGHLIGHT_COLOR  32'hFF000000  pixel value emitted for motion pixels
// PORTS
//  clk                input   1             single clock, rising edge
//  rst                input   1             synchronous, active-high reset
//  enable             input   1             advance pipeline and addresses this cycle (one input pixel accepted)
//  rbg_pixel          input   STREAM_WIDTH  current-frame pixel
//  memory_pixel       input   STREAM_WIDTH  background pixel for the same location, sampled with rbg_pixel
//  last_in_frame      input   1             rbg_pixel is the last pixel of its frame
//  wr_background      input   1             first-frame mode: pixel only seeds background, produces no output
//  threshold          input   8             motion threshold on grayscale difference
//  width              input   WIDTH_BITS    frame width in pixels (>=1)
//  height             input   HEIGHT_BITS   frame height in lines (>=1)
//  highlighted_pixel  output  STREAM_WIDTH  processed pixel
//  pixel_valid        output  1             highlighted_pixel/pixel_last hold a real output pixel
//  pixel_last         output  1             output pixel is last of frame
//  write_addr         output  ADDR_WIDTH    background write byte address for the current pixel
//  read_addr          output  ADDR_WIDTH    background read byte address for the current pixel
// BEHAVIOUR
//  Reset: every pipeline register, including all data stages, clears to 0.
//   - highlighted_pixel=0, pixel_valid=0, pixel_last=0, write_addr=read_addr=BASE_ADDR, counters=0.
//   - Reset wins over enable in the same cycle. Reset mid-frame drops in-flight pixels and restarts at pixel 0.
//  Pipeline: 3 register stages, all advance only on enable=1; enable=0 holds every stage (stall, no bubble insertion).
//   - S1: gray = (77*R + 150*G + 29*B) >> 8 for both pixels (16-bit products, 8-bit result).
//   - S1 also registers rbg_pixel, last_in_frame, and tag = !wr_background.
//   - S2: diff = |gray_cur - gray_bg| (8-bit, unsigned); motion = diff > threshold (strict).
//   - S3: highlighted_pixel = motion ? HIGHLIGHT_COLOR : original rbg_pixel.
//   - S3 outputs: pixel_valid = tag, pixel_last = last.
//  Latency: a pixel accepted on enable #k appears on the outputs after the clock edge of enable #k+2.
//   - The final 2 pixels of a frame drain only when the next frame's pixels are enabled.
//  wr_background=1 pixels traverse the pipeline with tag=0, so they never raise pixel_valid.
//  Position counters col/row:
//   - col increments on enable; at col==width-1 it wraps to 0 and row increments.
//   - enable & last_in_frame clears both regardless of position.
//   - row saturates at height-1 if last_in_frame is late.
//  Address generator:
//   - read_addr==write_addr at all times.
//   - Each enable adds 4 (STREAM_WIDTH/8); enable & last_in_frame reloads BASE_ADDR.
//   - Arithmetic is modulo 2^ADDR_WIDTH.
//   - Addresses are combinationally valid for the pixel being enabled.
//  Threshold, width and height are sampled live; the wrapper keeps them static after configuration.
// CONFIGURATION
//  EDGE_MASK_EN defined:
//   - motion is forced 0 for pixels with row==0, row==height-1, col==0 or col==width-1.
//   - Position is captured in S1 alongside the pixel.
//  EDGE_MASK_EN undefined: no masking; col/row still maintained but do not affect data.
// STRUCTURE
//  Package motion_pkg: pixel_t (STREAM_WIDTH logic), gray weights 77/150/29, PIPE_LATENCY=3, BYTES_PER_PIXEL=4.
//   - Also holds function rgb2gray(pixel_t) returning logic [7:0].
//  Sub-module frame_addr_gen (clk, rst, enable, last, write_addr, read_addr) implements the address generator.
//  Datapath and counters stay in motion_detect_core.
// TESTING
//  1. Reset, then enable with rbg=0x00FFFFFF, mem=0x00000000, thr=20, wr_background=0.
//     -> after 3rd enable edge: highlighted=0xFF000000, pixel_valid=1.
//  2. rbg=mem=0x00123456 with thr=0 -> highlighted=0x00123456 (diff 0 not > 0).
//     Gray difference exactly equal to thr -> no highlight.
//  3. 4-pixel frame with wr_background=1, last on pixel 3.
//     -> pixel_valid stays 0 throughout; addresses go 0,4,8,12 then back to BASE_ADDR.
//  4. Stall: toggle enable 1,0,0,1,1 -> outputs change only on enabled edges.
//     Stall must not reorder pixels or raise pixel_valid for a non-tagged slot.
//  5. width=4, height=2 with EDGE_MASK_EN and a large difference on every pixel.
//     -> all 8 pixels pass through unhighlighted. Without the macro: all 8 highlighted.
//  6. Assert rst mid-frame at pixel 5.
//     -> next cycle pixel_valid=0, write_addr=BASE_ADDR, col=row=0.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared types, weights and helpers for the motion-detection datapath.
// Used by motion_detect_core (optional build macro EDGE_MASK_EN) and frame_addr_gen.
package motion_pkg;

    localparam int unsigned PIXEL_WIDTH     = 32;
    localparam int unsigned PIPE_LATENCY    = 3;
    localparam int unsigned BYTES_PER_PIXEL = PIXEL_WIDTH / 8;

    // BT.601-style luma weights scaled by 256; they sum to exactly 256
    localparam logic [7:0] GRAY_W_R = 8'd77;
    localparam logic [7:0] GRAY_W_G = 8'd150;
    localparam logic [7:0] GRAY_W_B = 8'd29;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    // Stage-1 payload: original pixel plus both grayscale values
    typedef struct packed {
        pixel_t     pixel;
        logic [7:0] gray_cur;
        logic [7:0] gray_bg;
        logic       last;
        logic       tag;
    } s1_t;

    // Stage-2 payload: original pixel plus the motion decision
    typedef struct packed {
        pixel_t pixel;
        logic   motion;
        logic   last;
        logic   tag;
    } s2_t;

    // Weighted sum fits in 16 bits (max 256*255), so no overflow before the shift
    function automatic logic [7:0] rgb2gray(input pixel_t pix);
        logic [15:0] sum;
        logic        unused_alpha;
        unused_alpha = ^pix[31:24];
        sum = 16'(GRAY_W_R) * 16'(pix[23:16])
            + 16'(GRAY_W_G) * 16'(pix[15:8])
            + 16'(GRAY_W_B) * 16'(pix[7:0]);
        return sum[15:8];
    endfunction

    function automatic logic [7:0] absdiff8(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Background frame-buffer address generator: one pixel-sized step per accepted pixel,
// reloading the base address after the last pixel of a frame.
module frame_addr_gen
    import motion_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           STEP_BYTES = BYTES_PER_PIXEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  last,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [ADDR_WIDTH-1:0] read_addr
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Next address: hold on stall, wrap to base at end of frame, else step (modulo 2^ADDR_WIDTH)
    always_comb begin
        addr_d = addr_q;
        if (enable) begin
            if (last) begin
                addr_d = BASE_ADDR;
            end else begin
                addr_d = addr_q + ADDR_WIDTH'(STEP_BYTES);
            end
        end
    end

    // Address register with synchronous reset to the buffer base
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= BASE_ADDR;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Read and write target the same location: the background is updated in place
    assign write_addr = addr_q;
    assign read_addr  = addr_q;

endmodule

// File: rtl/motion_detect_core.sv
// Per-pixel motion detector: 3-stage grayscale-difference pipeline, frame position
// counters and background address generation.
// Build option: define EDGE_MASK_EN to suppress motion on the outer border of the frame.
module motion_detect_core
    import motion_pkg::*;
#(
    parameter int unsigned             WIDTH_BITS      = 11,
    parameter int unsigned             HEIGHT_BITS     = 10,
    parameter int unsigned             STREAM_WIDTH    = 32,
    parameter int unsigned             ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR       = '0,
    parameter logic [STREAM_WIDTH-1:0] HIGHLIGHT_COLOR = 32'hFF000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [STREAM_WIDTH-1:0] rbg_pixel,
    input  logic [STREAM_WIDTH-1:0] memory_pixel,
    input  logic                    last_in_frame,
    input  logic                    wr_background,
    input  logic [7:0]              threshold,
    input  logic [WIDTH_BITS-1:0]   width,
    input  logic [HEIGHT_BITS-1:0]  height,
    output logic [STREAM_WIDTH-1:0] highlighted_pixel,
    output logic                    pixel_valid,
    output logic                    pixel_last,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic [ADDR_WIDTH-1:0]   read_addr
);

    // ---------------------------------------------------------------------------------------
    // Frame position counters
    // ---------------------------------------------------------------------------------------
    logic [WIDTH_BITS-1:0]  col_q, col_d;
    logic [HEIGHT_BITS-1:0] row_q, row_d;
    logic                   col_at_end;
    logic                   row_at_end;

    assign col_at_end = (col_q == (width - WIDTH_BITS'(1)));
    assign row_at_end = (row_q == (height - HEIGHT_BITS'(1)));

    // Raster-order position of the pixel being accepted; last_in_frame always restarts
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (enable) begin
            if (last_in_frame) begin
                col_d = '0;
                row_d = '0;
            end else if (col_at_end) begin
                col_d = '0;
                // A late last_in_frame leaves the row parked on the bottom line
                if (!row_at_end) begin
                    row_d = row_q + HEIGHT_BITS'(1);
                end
            end else begin
                col_d = col_q + WIDTH_BITS'(1);
            end
        end
    end

    // Position counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Pixel pipeline
    // ---------------------------------------------------------------------------------------
    s1_t                     s1_q, s1_d;
    s2_t                     s2_q, s2_d;
    logic [STREAM_WIDTH-1:0] out_pixel_q, out_pixel_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    motion_masked;

`ifdef EDGE_MASK_EN
    logic s1_edge_q;
    logic edge_d;

    // Border pixels never report motion; position travels with the pixel from stage 1
    assign edge_d = (row_q == '0) | row_at_end | (col_q == '0) | col_at_end;

    // Border flag register, stalls together with the stage-1 payload
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_edge_q <= 1'b0;
        end else if (enable) begin
            s1_edge_q <= edge_d;
        end
    end

    assign motion_masked = s1_edge_q;
`else
    assign motion_masked = 1'b0;
`endif

    // S1: grayscale conversion of both pixels; background-seed pixels are untagged
    always_comb begin
        s1_d          = '0;
        s1_d.pixel    = pixel_t'(rbg_pixel);
        s1_d.gray_cur = rgb2gray(pixel_t'(rbg_pixel));
        s1_d.gray_bg  = rgb2gray(pixel_t'(memory_pixel));
        s1_d.last     = last_in_frame;
        s1_d.tag      = ~wr_background;
    end

    // S2: strict threshold on the absolute gray difference
    always_comb begin
        s2_d        = '0;
        s2_d.pixel  = s1_q.pixel;
        s2_d.motion = (absdiff8(s1_q.gray_cur, s1_q.gray_bg) > threshold) & ~motion_masked;
        s2_d.last   = s1_q.last;
        s2_d.tag    = s1_q.tag;
    end

    // S3: substitute the highlight colour for motion pixels
    always_comb begin
        out_pixel_d = s2_q.motion ? HIGHLIGHT_COLOR : STREAM_WIDTH'(s2_q.pixel);
        out_valid_d = s2_q.tag;
        out_last_d  = s2_q.last;
    end

    // Pipeline registers: all stages advance together on enable, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_pixel_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (enable) begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_pixel_q <= out_pixel_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign highlighted_pixel = out_pixel_q;
    assign pixel_valid       = out_valid_q;
    assign pixel_last        = out_last_q;

    // ---------------------------------------------------------------------------------------
    // Background buffer addressing
    // ---------------------------------------------------------------------------------------
    frame_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .STEP_BYTES (STREAM_WIDTH / 8)
    ) u_frame_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .last       (last_in_frame),
        .write_addr (write_addr),
        .read_addr  (read_addr)
    );

endmodule

// File: tb/tb_motion_detect_core.sv
// Self-checking bench for motion_detect_core; expectations follow EDGE_MASK_EN when defined.
`timescale 1ns/1ps
module tb_motion_detect_core;

    localparam logic [31:0] HL   = 32'hFF000000;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst, enable, last_in_frame, wr_background;
    logic [31:0] rbg_pixel, memory_pixel;
    logic [7:0]  threshold;
    logic [10:0] width;
    logic [9:0]  height;
    logic [31:0] highlighted_pixel, write_addr, read_addr;
    logic        pixel_valid, pixel_last;

    always #5 clk = ~clk;

    motion_detect_core dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .rbg_pixel         (rbg_pixel),
        .memory_pixel      (memory_pixel),
        .last_in_frame     (last_in_frame),
        .wr_background     (wr_background),
        .threshold         (threshold),
        .width             (width),
        .height            (height),
        .highlighted_pixel (highlighted_pixel),
        .pixel_valid       (pixel_valid),
        .pixel_last        (pixel_last),
        .write_addr        (write_addr),
        .read_addr         (read_addr)
    );

    typedef struct packed {
        logic [31:0] pix;
        logic        valid;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          m_col, m_row;
    logic [31:0] m_addr;

    function automatic int gray_of(input logic [31:0] p);
        return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
    endfunction

    // Drive one cycle of inputs at the falling edge and update the reference model
    task automatic drive(input logic en, input logic r, input logic [31:0] rbg,
                         input logic [31:0] mem, input logic lst, input logic wrb);
        exp_t e;
        int   gc, gb, diff;
        logic motion;
        @(negedge clk);
        rst = r; enable = en; rbg_pixel = rbg; memory_pixel = mem;
        last_in_frame = lst; wr_background = wrb;
        if (r) begin
            sb_q.delete();
            sb_q.push_back('0);
            sb_q.push_back('0);
            m_col = 0; m_row = 0; m_addr = BASE;
        end else if (en) begin
            gc = gray_of(rbg);
            gb = gray_of(mem);
            diff = (gc > gb) ? gc - gb : gb - gc;
            motion = (diff > int'(threshold));
`ifdef EDGE_MASK_EN
            if (m_row == 0 || m_row == int'(height) - 1 || m_col == 0 || m_col == int'(width) - 1)
                motion = 1'b0;
`endif
            e.pix = motion ? HL : rbg;
            e.valid = !wrb;
            e.last = lst;
            sb_q.push_back(e);
            if (lst) begin
                m_col = 0; m_row = 0; m_addr = BASE;
            end else begin
                m_addr = m_addr + 32'd4;
                if (m_col == int'(width) - 1) begin
                    m_col = 0;
                    if (m_row != int'(height) - 1) m_row++;
                end else begin
                    m_col++;
                end
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Two untagged zero pixels: drains the pipeline and ends the frame
    task automatic flush;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1); tick;
    endtask

    // Scoreboard: pop on every enabled edge, otherwise outputs must hold
    logic [31:0] hold_pix;
    logic        hold_valid, hold_last;
    always @(posedge clk) begin : monitor
        logic s_en, s_rst;
        exp_t e;
        s_en = enable;
        s_rst = rst;
        #1;
        if (s_rst === 1'b0 && s_en === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: output produced with empty scoreboard at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                if (highlighted_pixel !== e.pix) begin
                    n_err++;
                    $display("FAIL sb_pixel: got %h want %h at %0t", highlighted_pixel, e.pix, $time);
                end
                n_cmp++;
                if (pixel_valid !== e.valid) begin
                    n_err++;
                    $display("FAIL sb_valid: got %b want %b at %0t", pixel_valid, e.valid, $time);
                end
                n_cmp++;
                if (pixel_last !== e.last) begin
                    n_err++;
                    $display("FAIL sb_last: got %b want %b at %0t", pixel_last, e.last, $time);
                end
            end
        end else if (s_rst === 1'b0 && s_en === 1'b0) begin
            n_cmp++;
            if ({highlighted_pixel, pixel_valid, pixel_last} !== {hold_pix, hold_valid, hold_last}) begin
                n_err++;
                $display("FAIL stall_hold: got %h/%b/%b want %h/%b/%b at %0t", highlighted_pixel,
                         pixel_valid, pixel_last, hold_pix, hold_valid, hold_last, $time);
            end
        end
        hold_pix = highlighted_pixel;
        hold_valid = pixel_valid;
        hold_last = pixel_last;
    end

    task automatic test_reset;
        threshold = 8'd20; width = 11'd4; height = 10'd4;
        // enable high during reset: reset must win
        drive(1'b1, 1'b1, 32'h00FFFFFF, 32'h0, 1'b0, 1'b0); tick;
        drive(1'b0, 1'b1, 32'h00FFFFFF, 32'h0, 1'b0, 1'b0); tick;
        n_cmp++;
        if (highlighted_pixel !== 32'h0) begin
            n_err++; $display("FAIL reset_pixel: got %h want 0", highlighted_pixel);
        end
        n_cmp++;
        if (pixel_valid !== 1'b0 || pixel_last !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: got %b/%b want 0/0", pixel_valid, pixel_last);
        end
        n_cmp++;
        if (write_addr !== BASE || read_addr !== BASE) begin
            n_err++; $display("FAIL reset_addr: got %h/%h want %h", write_addr, read_addr, BASE);
        end
        n_cmp++;
        if (dut.col_q !== 11'd0 || dut.row_q !== 10'd0) begin
            n_err++; $display("FAIL reset_pos: got %0d/%0d want 0/0", dut.col_q, dut.row_q);
        end
    endtask

    task automatic test_motion_basic;
        threshold = 8'd20;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h00FFFFFF, 32'h0, 1'b0, 1'b0); tick;
        end
        n_cmp++;
        if (highlighted_pixel !== 32'hFF000000 || pixel_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_motion: got %h/%b want ff000000/1", highlighted_pixel, pixel_valid);
        end
        flush();
    endtask

    task automatic test_threshold;
        logic [7:0]  thr_tab[3];
        logic [31:0] cur_tab[3];
        logic [31:0] bg_tab[3];
        logic [31:0] want_tab[3];
        thr_tab  = '{8'd0, 8'd16, 8'd15};
        cur_tab  = '{32'h00123456, 32'h00505050, 32'h00505050};
        bg_tab   = '{32'h00123456, 32'h00404040, 32'h00404040};
        want_tab = '{32'h00123456, 32'h00505050, 32'hFF000000};
        for (int t = 0; t < 3; t++) begin
            threshold = thr_tab[t];
            for (int i = 0; i < 3; i++) begin
                drive(1'b1, 1'b0, cur_tab[t], bg_tab[t], 1'b0, 1'b0); tick;
            end
            n_cmp++;
            if (highlighted_pixel !== want_tab[t]) begin
                n_err++;
                $display("FAIL threshold_%0d: got %h want %h", t, highlighted_pixel, want_tab[t]);
            end
            flush();
        end
    endtask

    task automatic test_wr_background;
        threshold = 8'd20;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h00FFFFFF, 32'h0, (i == 3), 1'b1);
            n_cmp++;
            if (write_addr !== 32'(i * 4) || read_addr !== 32'(i * 4)) begin
                n_err++;
                $display("FAIL bg_addr_%0d: got %h/%h want %h", i, write_addr, read_addr, i * 4);
            end
            tick;
        end
        n_cmp++;
        if (write_addr !== BASE) begin
            n_err++; $display("FAIL bg_addr_wrap: got %h want %h", write_addr, BASE);
        end
        // outputs on these two edges are background pixels 2 and 3
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick;
            n_cmp++;
            if (pixel_valid !== 1'b0) begin
                n_err++; $display("FAIL bg_valid_%0d: got %b want 0", i, pixel_valid);
            end
        end
        flush();
    endtask

    task automatic test_stall;
        logic [31:0] addr_before;
        threshold = 8'd20;
        drive(1'b1, 1'b0, 32'h00FFFFFF, 32'h0, 1'b0, 1'b0); tick;
        addr_before = m_addr;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, $urandom, $urandom, 1'b1, 1'b0); tick;
        end
        n_cmp++;
        if (write_addr !== addr_before) begin
            n_err++; $display("FAIL stall_addr: got %h want %h", write_addr, addr_before);
        end
        drive(1'b1, 1'b0, 32'h00102030, 32'h00102030, 1'b0, 1'b1); tick;
        drive(1'b1, 1'b0, 32'h00AABBCC, 32'h0, 1'b0, 1'b0); tick;
        flush();
    endtask

    task automatic test_edge_mask;
        int n_valid, n_hl, want_hl;
        n_valid = 0; n_hl = 0;
`ifdef EDGE_MASK_EN
        want_hl = 0;
`else
        want_hl = 8;
`endif
        drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0); tick;
        width = 11'd4; height = 10'd2; threshold = 8'd10;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, 1'b0, 32'h00FFFFFF, 32'h0, (i == 7), 1'b0);
            else       drive(1'b1, 1'b0, 32'h0, 32'h0, (i == 9), 1'b1);
            tick;
            if (pixel_valid === 1'b1) n_valid++;
            if (pixel_valid === 1'b1 && highlighted_pixel === HL) n_hl++;
        end
        n_cmp++;
        if (n_valid != 8) begin
            n_err++; $display("FAIL edge_valid_count: got %0d want 8", n_valid);
        end
        n_cmp++;
        if (n_hl != want_hl) begin
            n_err++; $display("FAIL edge_highlight_count: got %0d want %0d", n_hl, want_hl);
        end
    endtask

    task automatic test_reset_mid_frame;
        width = 11'd4; height = 10'd4; threshold = 8'd20;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, $urandom & 32'h00FFFFFF, $urandom & 32'h00FFFFFF, 1'b0, 1'b0); tick;
        end
        drive(1'b1, 1'b1, 32'h00FFFFFF, 32'h0, 1'b0, 1'b0); tick;
        n_cmp++;
        if (pixel_valid !== 1'b0 || highlighted_pixel !== 32'h0) begin
            n_err++;
            $display("FAIL midrst_out: got %b/%h want 0/0", pixel_valid, highlighted_pixel);
        end
        n_cmp++;
        if (write_addr !== BASE || read_addr !== BASE) begin
            n_err++; $display("FAIL midrst_addr: got %h/%h want %h", write_addr, read_addr, BASE);
        end
        n_cmp++;
        if (dut.col_q !== 11'd0 || dut.row_q !== 10'd0) begin
            n_err++; $display("FAIL midrst_pos: got %0d/%0d want 0/0", dut.col_q, dut.row_q);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, $urandom & 32'h00FFFFFF, $urandom & 32'h00FFFFFF, (i == 3), 1'b0);
            tick;
        end
        flush();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; rbg_pixel = '0; memory_pixel = '0;
        last_in_frame = 1'b0; wr_background = 1'b0;
        threshold = 8'd20; width = 11'd4; height = 10'd4;
        test_reset();
        test_motion_basic();
        test_threshold();
        test_wr_background();
        test_stall();
        test_edge_mask();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
